// File: rtl/adc_sample_buffer_pkg.sv
// adc_sample_buffer_pkg: shared widths, FIFO/burst defaults and burst state encoding for the ADC capture path and FX3 state machine
package adc_sample_buffer_pkg;
  localparam int DATA_W = 16;
  localparam int ADC_W = 10;
  localparam int DEPTH_LOG2_DEF = 13;
  localparam int BURST_WORDS_DEF = 8192;
  typedef enum logic {IDLE, BURST} burst_state_t;
endpackage

// File: rtl/sample_fifo_ram.sv
// sample_fifo_ram: 2**AW x DATA_W simple dual-port RAM; ports clk_i, we_i/waddr_i/wdata_i write, re_i/raddr_i read, rdata_o registered read data (old data on collision)
module sample_fifo_ram
  import adc_sample_buffer_pkg::*;
#(
  parameter int AW = DEPTH_LOG2_DEF
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [2**AW];
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/adc_sample_buffer.sv
// adc_sample_buffer: ADC-to-FX3 sample FIFO with burst handshake; in inclk/reset/collectData/testMode/adcData/adcStrobe/fx3isReading, out dataAvailable/dataOut/overflow/underrun
module adc_sample_buffer
  import adc_sample_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int BURST_WORDS = BURST_WORDS_DEF
) (
  input  logic              inclk,
  input  logic              reset,
  input  logic              collectData,
  input  logic              testMode,
  input  logic [ADC_W-1:0]  adcData,
  input  logic              adcStrobe,
  input  logic              fx3isReading,
  output logic              dataAvailable,
  output logic [DATA_W-1:0] dataOut,
  output logic              overflow,
  output logic              underrun
);
  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] FULL_C = CW'(2**DEPTH_LOG2);
  localparam logic [CW-1:0] BURST_C = CW'(BURST_WORDS);
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d, burst_cnt_q, burst_cnt_d;
  logic [ADC_W-1:0] test_cnt_q;
  logic [DATA_W-1:0] ram_q;
  logic collect_q, zero_q, rise, full, empty, strobe, pop, push, last;
  burst_state_t state_q, state_d;
  always_comb begin
    rise = collectData & ~collect_q;
    full = count_q == FULL_C;
    empty = count_q == '0;
    strobe = adcStrobe & collectData & ~rise;
    pop = fx3isReading & ~empty & ~rise;
    push = strobe & (~full | pop);
    last = burst_cnt_q == BURST_C - 1'b1;
    count_d = rise ? '0 : count_q + CW'(push) - CW'(pop);
    burst_cnt_d = rise ? '0 : pop ? (last ? '0 : burst_cnt_q + 1'b1) : burst_cnt_q;
    state_d = rise ? IDLE : pop ? (last ? IDLE : BURST) : state_q;
  end
  sample_fifo_ram #(.AW(DEPTH_LOG2)) u_ram (
    .clk_i(inclk),
    .we_i(push),
    .waddr_i(wr_ptr_q),
    .wdata_i(DATA_W'(testMode ? test_cnt_q : adcData)),
    .re_i(pop),
    .raddr_i(rd_ptr_q),
    .rdata_o(ram_q)
  );
  // zero_q masks the RAM output after reset or an empty read so dataOut shows 0
  assign dataOut = zero_q ? '0 : ram_q;
  always_ff @(posedge inclk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      burst_cnt_q <= '0;
      test_cnt_q <= '0;
      collect_q <= 1'b0;
      zero_q <= 1'b1;
      state_q <= IDLE;
      dataAvailable <= 1'b0;
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      collect_q <= collectData;
      count_q <= count_d;
      burst_cnt_q <= burst_cnt_d;
      state_q <= state_d;
      dataAvailable <= state_d == IDLE && count_d >= BURST_C;
      wr_ptr_q <= rise ? '0 : wr_ptr_q + DEPTH_LOG2'(push);
      rd_ptr_q <= rise ? '0 : rd_ptr_q + DEPTH_LOG2'(pop);
      test_cnt_q <= rise ? '0 : test_cnt_q + ADC_W'(strobe);
      overflow <= ~rise & (overflow | (strobe & full & ~pop));
      underrun <= ~rise & (underrun | (fx3isReading & empty));
      if (fx3isReading & ~rise) zero_q <= empty;
    end
  end
endmodule
